// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_wr_arbiter_pkg: state encoding, default sizes and index helper shared by the FIFO write arbiter
package fifo_wr_arbiter_pkg;
  localparam logic [1:0] IDLE        = 2'b00;
  localparam logic [1:0] SEND_FIRST  = 2'b01;
  localparam logic [1:0] SEND_SECOND = 2'b10;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_REQ    = 2;
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// rr_priority_picker: combinational round-robin winner search starting at the priority pointer
module rr_priority_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int PTR_BITS = 1
)(
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [PTR_BITS-1:0] winner,
  output logic                any_valid
);
  logic [PTR_BITS-1:0] j;
  // scan from the farthest offset back toward the pointer so the nearest requester is written last
  always_comb begin
    winner = '0;
    j = '0;
    any_valid = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = PTR_BITS'(wrap_idx(int'(ptr), k, NUM_REQ));
      winner = req[j] ? j : winner;
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port; FIFO_ARB_MSB_FIRST_EN sends 2-byte words high byte first
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int PTR_BITS   = 1
)(
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]            REQ_TWO,
  input  logic                          W_FULL,
  output logic                          WINC,
  output logic [DATA_WIDTH-1:0]         W_DATA,
  output logic [NUM_REQ-1:0]            ACK,
  output logic                          BUSY
);
  localparam int WW = 2 * DATA_WIDTH;
  logic [1:0]          state_q, state_d;
  logic [WW-1:0]       word_q, word_d;
  logic                two_q, two_d;
  logic [PTR_BITS-1:0] gnt_q, gnt_d, ptr_q, ptr_d, win;
  logic                any_req, last_byte, send_hi;
  logic [WW-1:0]       req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_word[i] = REQ_DATA[i*WW +: WW];
  end

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .PTR_BITS(PTR_BITS)) u_pick (
    .req       (REQ),
    .ptr       (ptr_q),
    .winner    (win),
    .any_valid (any_req)
  );

  // byte lane select, write strobe gated by full, and one-hot completion on the final byte
  always_comb begin
    last_byte = (state_q == SEND_SECOND) || (state_q == SEND_FIRST && !two_q);
`ifdef FIFO_ARB_MSB_FIRST_EN
    send_hi = state_q == SEND_FIRST && two_q;
`else
    send_hi = state_q == SEND_SECOND;
`endif
    WINC = state_q != IDLE && !W_FULL;
    W_DATA = send_hi ? word_q[WW-1:DATA_WIDTH] : word_q[DATA_WIDTH-1:0];
    ACK = (WINC && last_byte) ? NUM_REQ'(1) << gnt_q : '0;
    BUSY = state_q != IDLE;
  end

  // grant latches the winner's word and advances the pointer; each accepted byte steps the sequence
  always_comb begin
    state_d = state_q;
    word_d = word_q;
    two_d = two_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (state_q == IDLE) begin
      if (any_req) begin
        state_d = SEND_FIRST;
        word_d = req_word[win];
        two_d = REQ_TWO[win];
        gnt_d = win;
        ptr_d = PTR_BITS'(wrap_idx(int'(win), 1, NUM_REQ));
      end
    end else if (WINC) begin
      state_d = (state_q == SEND_FIRST && two_q) ? SEND_SECOND : IDLE;
    end
  end

  // state registers; reset abandons any word in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      word_q <= '0;
      two_q <= 1'b0;
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      word_q <= word_d;
      two_q <= two_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and random scoreboard checks of the FIFO write arbiter
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int N = 2;
  localparam int WW = 2 * DW;

  typedef struct {
    logic [DW-1:0] b;
    logic [N-1:0]  a;
  } exp_t;

  logic clk = 1'b0;
  logic rst, rst_v, w_full, winc, busy;
  logic [N-1:0] req, req_two, ack;
  logic [N*WW-1:0] req_data;
  logic [DW-1:0] w_data;

  exp_t sb[$];
  logic [DW-1:0] wr_log[$];
  logic [N-1:0] ack_log[$];
  int tests = 0;
  int fails = 0;
  bit m_busy, hold, rnd;
  int m_ptr;
  logic [WW-1:0] p_data [N];
  bit p_two [N];
  bit p_req [N];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .PTR_BITS(1)) dut (
    .CLK      (clk),
    .RST      (rst),
    .REQ      (req),
    .REQ_DATA (req_data),
    .REQ_TWO  (req_two),
    .W_FULL   (w_full),
    .WINC     (winc),
    .W_DATA   (w_data),
    .ACK      (ack),
    .BUSY     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic grant();
    int w;
    logic [WW-1:0] d;
    logic [N-1:0] a, z;
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    d = req_data[w*WW +: WW];
    a = '0;
    a[w] = 1'b1;
    z = '0;
    if (req_two[w]) begin
`ifdef FIFO_ARB_MSB_FIRST_EN
      sb.push_back('{d[15:8], z});
      sb.push_back('{d[7:0], a});
`else
      sb.push_back('{d[7:0], z});
      sb.push_back('{d[15:8], a});
`endif
    end else sb.push_back('{d[7:0], a});
    m_ptr = (w + 1) % N;
    m_busy = 1'b1;
  endtask

  task automatic sample();
    exp_t e;
    if (!rst) begin
      m_busy = 1'b0;
      m_ptr = 0;
      sb.delete();
    end
    chk("busy", busy, m_busy);
    if (rst && !m_busy && |req) grant();
    if (winc) begin
      wr_log.push_back(w_data);
      if (|ack) ack_log.push_back(ack);
      chk("winc_while_full", w_full, 0);
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow got=%0h want=no write", w_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("w_data", w_data, e.b);
        chk("ack", ack, e.a);
        if (e.a != 0) begin
          m_busy = 1'b0;
          for (int i = 0; i < N; i++) if (e.a[i] && !hold) p_req[i] = 1'b0;
        end
      end
    end else chk("ack_no_winc", ack, 0);
  endtask

  task automatic cyc(input bit full);
    @(posedge clk);
    #1;
    if (rnd)
      for (int i = 0; i < N; i++) begin
        p_data[i] = WW'($urandom);
        if (!p_req[i] && $urandom_range(0, 1) == 1) begin
          p_req[i] = 1'b1;
          p_two[i] = 1'($urandom_range(0, 1));
        end
      end
    rst = rst_v;
    w_full = full;
    for (int i = 0; i < N; i++) begin
      req[i] = p_req[i];
      req_two[i] = p_two[i];
      req_data[i*WW +: WW] = p_data[i];
    end
    @(negedge clk);
    sample();
  endtask

  task automatic clear_logs();
    wr_log.delete();
    ack_log.delete();
  endtask

  initial begin
    int guard;
    logic [DW-1:0] b0, b1;
`ifdef FIFO_ARB_MSB_FIRST_EN
    b0 = 8'hA5;
    b1 = 8'h5A;
`else
    b0 = 8'h5A;
    b1 = 8'hA5;
`endif
    rst = 1'b0;
    rst_v = 1'b0;
    w_full = 1'b0;
    req = '0;
    req_two = '0;
    req_data = '0;
    hold = 1'b0;
    rnd = 1'b0;
    m_busy = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      p_data[i] = '0;
      p_two[i] = 1'b0;
      p_req[i] = 1'b0;
    end
    repeat (3) cyc(0);
    chk("rst_winc", winc, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wdata", w_data, 0);
    rst_v = 1'b1;
    repeat (10) begin
      cyc(0);
      chk("idle_winc", winc, 0);
      chk("idle_ack", ack, 0);
      chk("idle_wdata", w_data, 0);
    end

    clear_logs();
    p_data[0] = 16'hA55A;
    p_two[0] = 1'b1;
    p_req[0] = 1'b1;
    repeat (4) cyc(0);
    chk("a55a_count", wr_log.size(), 2);
    chk("a55a_byte0", wr_log[0], b0);
    chk("a55a_byte1", wr_log[1], b1);
    chk("a55a_acks", ack_log.size(), 1);
    chk("a55a_ack", ack_log[0], 2'b01);

    clear_logs();
    p_data[0] = 16'hBEEF;
    p_two[0] = 1'b1;
    p_req[0] = 1'b1;
    cyc(0);
    repeat (3) begin
      cyc(1);
      chk("stall_winc", winc, 0);
      chk("stall_busy", busy, 1);
`ifdef FIFO_ARB_MSB_FIRST_EN
      chk("stall_wdata", w_data, 8'hBE);
`else
      chk("stall_wdata", w_data, 8'hEF);
`endif
    end
    repeat (3) cyc(0);
    chk("beef_count", wr_log.size(), 2);
`ifdef FIFO_ARB_MSB_FIRST_EN
    chk("beef_byte0", wr_log[0], 8'hBE);
    chk("beef_byte1", wr_log[1], 8'hEF);
`else
    chk("beef_byte0", wr_log[0], 8'hEF);
    chk("beef_byte1", wr_log[1], 8'hBE);
`endif
    chk("beef_acks", ack_log.size(), 1);

    rst_v = 1'b0;
    repeat (2) cyc(0);
    rst_v = 1'b1;
    cyc(0);
    clear_logs();
    hold = 1'b1;
    p_data[0] = 16'h0011;
    p_two[0] = 1'b0;
    p_data[1] = 16'h2233;
    p_two[1] = 1'b0;
    p_req[0] = 1'b1;
    p_req[1] = 1'b1;
    repeat (8) cyc(0);
    p_req[0] = 1'b0;
    p_req[1] = 1'b0;
    hold = 1'b0;
    cyc(0);
    chk("rr_count", wr_log.size(), 4);
    chk("rr_byte0", wr_log[0], 8'h11);
    chk("rr_byte1", wr_log[1], 8'h33);
    chk("rr_byte2", wr_log[2], 8'h11);
    chk("rr_byte3", wr_log[3], 8'h33);
    chk("rr_acks", ack_log.size(), 4);
    chk("rr_ack0", ack_log[0], 2'b01);
    chk("rr_ack1", ack_log[1], 2'b10);
    chk("rr_ack2", ack_log[2], 2'b01);
    chk("rr_ack3", ack_log[3], 2'b10);

    p_data[0] = 16'h1234;
    p_two[0] = 1'b1;
    p_req[0] = 1'b1;
    cyc(0);
    cyc(0);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    rst_v = 1'b0;
    #1;
    chk("midrst_winc", winc, 0);
    chk("midrst_ack", ack, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    sample();
    clear_logs();
    repeat (2) cyc(0);
    rst_v = 1'b1;
    repeat (4) cyc(0);
    chk("regrant_count", wr_log.size(), 2);
`ifdef FIFO_ARB_MSB_FIRST_EN
    chk("regrant_byte0", wr_log[0], 8'h12);
    chk("regrant_byte1", wr_log[1], 8'h34);
`else
    chk("regrant_byte0", wr_log[0], 8'h34);
    chk("regrant_byte1", wr_log[1], 8'h12);
`endif
    chk("regrant_acks", ack_log.size(), 1);
    chk("regrant_ack", ack_log[0], 2'b01);

    rnd = 1'b1;
    repeat (1000) cyc($urandom_range(0, 99) < 30);
    rnd = 1'b0;
    guard = 0;
    while ((busy || |req || sb.size() != 0) && guard < 100) begin
      cyc(0);
      guard++;
    end
    chk("drain_in_time", guard < 100, 1);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single FIFO write port (WINC/W_DATA/W_FULL) between NUM_REQ producers, e.g. ALU result path and register-file read path.
- Each producer offers a 2-byte word plus a byte count (1 or 2 bytes).
- The block grants one producer and serializes its bytes into the FIFO at one byte per accepted cycle, stalling on W_FULL.
- Sits in the write-clock domain, directly upstream of the FIFO write side.

Parameters:
- DATA_WIDTH, 8, FIFO byte width.
- NUM_REQ, 2, number of producers (2..8).
- PTR_BITS, 1, width of grant index; must equal clog2(NUM_REQ).

Ports:
- CLK  in  1  write-domain clock.
- RST  in  1  asynchronous active-low reset.
- REQ  in  NUM_REQ  per-producer request; held high until its ACK.
- REQ_DATA  in  NUM_REQ*2*DATA_WIDTH  packed words; producer i at bits [(i+1)*2*DATA_WIDTH-1 : i*2*DATA_WIDTH].
- REQ_TWO  in  NUM_REQ  1 = send both bytes, 0 = low byte only.
- W_FULL  in  1  FIFO full flag, already synchronized into CLK domain.
- WINC  out  1  FIFO write enable.
- W_DATA  out  DATA_WIDTH  byte to FIFO.
- ACK  out  NUM_REQ  one-hot, one-cycle; high in the cycle the producer's final byte is written.
- BUSY  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, RST low), regardless of state:
  - state=IDLE, holding word=0, grant index=0, priority pointer=0.
  - WINC=0, W_DATA=0, ACK=0, BUSY=0.
  - A transfer in progress is abandoned with no ACK.
- FSM states: IDLE, SEND_FIRST, SEND_SECOND.
- IDLE:
  - If any REQ is high, pick the first requester at or after the priority pointer (wrapping modulo NUM_REQ).
  - On that edge, latch REQ_DATA[i], REQ_TWO[i] and index i, then go to SEND_FIRST.
  - No REQ: stay in IDLE.
- SEND_FIRST:
  - W_DATA = low byte (default order).
  - WINC = !W_FULL (combinational).
  - If WINC is high: go to SEND_SECOND when TWO=1; otherwise raise ACK[i] in this cycle and go to IDLE.
  - If W_FULL is high: hold state and data, WINC=0.
- SEND_SECOND:
  - W_DATA = high byte, WINC = !W_FULL.
  - When WINC is high: ACK[i]=1 this cycle, go to IDLE.
- ACK = WINC & final-byte state, decoded to one-hot of the grant index. The producer drops REQ at the same edge the arbiter returns to IDLE.
- Priority pointer updates to (i+1) mod NUM_REQ on the grant edge, not on ACK.
- Latency, FIFO never full:
  - 1-byte word: grant edge, then 1 write cycle; next grant possible on the following edge.
  - 2-byte word: 2 write cycles.
  - Sustained throughput: 1 byte/cycle plus 1 IDLE cycle per word.
- A producer's REQ_DATA changing after grant has no effect; the latched copy is used.
- REQ deasserted after grant, before ACK: illegal. The transfer still completes and ACK still pulses.
- W_FULL toggling mid-word: stall cycle-by-cycle; no byte is skipped or duplicated.
- WINC is never high while W_FULL is high.
- W_DATA is always driven from the holding register, so it is stable during a stall.

Optional Feature:
- Macro FIFO_ARB_MSB_FIRST_EN.
- Defined: for 2-byte words, SEND_FIRST drives the high byte and SEND_SECOND the low byte. 1-byte words still send the low byte only.
- Undefined: low byte first, as specified above.

Decomposition:
- Shared package/include holds:
  - State encoding localparams: IDLE=2'b00, SEND_FIRST=2'b01, SEND_SECOND=2'b10.
  - Default DATA_WIDTH / NUM_REQ constants.
- One sub-module is natural: rr_priority_picker (combinational).
  - Inputs: REQ vector, pointer.
  - Outputs: winner index, any-valid flag.
  - Instantiated once.

Test Plan:
- Reset value check: RST low for 3 cycles, then high with no REQ -> WINC, ACK, BUSY stay 0 for 10 cycles; W_DATA=0.
- Single 2-byte word: REQ[0]=1, data 16'hA55A, TWO=1, W_FULL=0 -> cycle 1 WINC=1, W_DATA=5A; cycle 2 WINC=1, W_DATA=A5, ACK=01. With FIFO_ARB_MSB_FIRST_EN: A5 then 5A.
- Round-robin: REQ=11 held, producer0=16'h0011 (TWO=0), producer1=16'h2233 (TWO=0) -> FIFO receives 11,33,11,33; ACK alternates 01,10.
- Backpressure: 2-byte word 16'hBEEF, W_FULL high in the first byte cycle for 3 cycles -> WINC=0 and W_DATA=EF held; then EF, BE written exactly once each; ACK once.
- Reset mid-word: assert RST during SEND_SECOND of 16'h1234 -> no ACK, WINC=0 immediately; after release the arbiter regrants from producer 0 and resends 34,12.
- Scoreboard over 1000 random REQ/W_FULL cycles -> FIFO byte stream equals the per-grant expected sequence; no WINC while W_FULL is high.
